// File: rtl/uart_pkg.sv
// Shared constants, FSM state encodings and divisor rounding for the UART slice.
package uart_pkg;

    localparam int unsigned DataWidth  = 8;
    localparam int unsigned Oversample = 16;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    function automatic int unsigned round_div(input int unsigned num, input int unsigned den);
        return (num + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running dividers producing the bit tick (tx_clk) and the 16x oversample tick (rx_clk).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 30000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic tx_clk,
    output logic rx_clk
);

    localparam int unsigned TxDiv  = round_div(CLK_FREQ, BAUD);
    localparam int unsigned RxDiv  = round_div(CLK_FREQ, Oversample * BAUD);
    localparam int unsigned TxCntW = (TxDiv > 1) ? $clog2(TxDiv) : 1;
    localparam int unsigned RxCntW = (RxDiv > 1) ? $clog2(RxDiv) : 1;
    localparam logic [TxCntW-1:0] TxLast = TxCntW'(TxDiv - 1);
    localparam logic [RxCntW-1:0] RxLast = RxCntW'(RxDiv - 1);

    logic [TxCntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [RxCntW-1:0] rx_cnt_q, rx_cnt_d;
    logic              tx_clk_q, rx_clk_q;

    always_comb begin
        tx_cnt_d = (tx_cnt_q == TxLast) ? '0 : tx_cnt_q + TxCntW'(1);
        rx_cnt_d = (rx_cnt_q == RxLast) ? '0 : rx_cnt_q + RxCntW'(1);
    end

    // Ticks are registered so both are clean one-cycle pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            tx_clk_q <= 1'b0;
            rx_clk_q <= 1'b0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            tx_clk_q <= (tx_cnt_q == TxLast);
            rx_clk_q <= (rx_cnt_q == RxLast);
        end
    end

    assign tx_clk = tx_clk_q;
    assign rx_clk = rx_clk_q;

endmodule

// File: rtl/uart.sv
// 8N1 UART: bit-tick driven transmitter and 16x-oversampling receiver, fully independent.
module uart
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 30000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    output logic                 tx_clk,
    output logic                 rx_clk,
    input  logic                 tx_en,
    input  logic [DataWidth-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic [DataWidth-1:0] rx_data,
    input  logic                 rx,
    output logic                 rx_ready,
    input  logic                 rx_ready_clear
);

    localparam int unsigned BitW  = $clog2(DataWidth);
    localparam int unsigned TickW = $clog2(Oversample);
    localparam logic [BitW-1:0]  LastBit  = BitW'(DataWidth - 1);
    localparam logic [TickW-1:0] HalfTick = TickW'(Oversample / 2 - 1);
    localparam logic [TickW-1:0] FullTick = TickW'(Oversample - 1);

    uart_baud_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tx_clk    (tx_clk),
        .rx_clk    (rx_clk)
    );

    // Transmitter. tx_pend_q marks a byte accepted in idle, waiting for the next bit tick.
    tx_state_e            tx_state_q, tx_state_d;
    logic                 tx_pend_q, tx_pend_d;
    logic [DataWidth-1:0] tx_shift_q, tx_shift_d;
    logic [BitW-1:0]      tx_bit_q, tx_bit_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_state_q <= TxIdle;
            tx_pend_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_pend_q  <= tx_pend_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_pend_d  = tx_pend_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        unique case (tx_state_q)
            TxIdle: begin
                if (!tx_pend_q) begin
                    if (tx_en) begin
                        tx_pend_d  = 1'b1;
                        tx_shift_d = tx_data;
                    end
                end else if (tx_clk) begin
                    tx_pend_d  = 1'b0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_clk) begin
                    tx_state_d = TxData;
                    tx_bit_d   = '0;
                end
            end
            TxData: begin
                if (tx_clk) begin
                    tx_bit_d = tx_bit_q + BitW'(1);
                    if (tx_bit_q == LastBit) tx_state_d = TxStop;
                end
            end
            TxStop: begin
                if (tx_clk) tx_state_d = TxIdle;
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        tx_busy = tx_pend_q | (tx_state_q != TxIdle);
        unique case (tx_state_q)
            TxStart: tx = 1'b0;
            TxData:  tx = tx_shift_q[tx_bit_q];
            default: tx = 1'b1;
        endcase
    end

    // Receiver front end: two-flop synchronizer plus one delayed copy for edge detection.
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    rx_state_e            rx_state_q, rx_state_d;
    logic [TickW-1:0]     rx_tick_q, rx_tick_d;
    logic [BitW-1:0]      rx_bit_q, rx_bit_d;
    logic [DataWidth-1:0] rx_shift_q, rx_shift_d;
    logic [DataWidth-1:0] rx_data_q, rx_data_d;
    logic                 rx_ready_q, rx_ready_d;
    logic                 rx_sample, rx_byte_ok;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_state_q <= RxIdle;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        if (rx_clk && (rx_state_q != RxIdle)) rx_tick_d = rx_tick_q + TickW'(1);
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RxStart;
                    rx_tick_d  = '0;
                end
            end
            RxStart: begin
                // A line that is high again at mid start bit was a glitch.
                if (rx_sample) begin
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                    rx_tick_d  = '0;
                    rx_bit_d   = '0;
                end
            end
            RxData: begin
                if (rx_sample) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[DataWidth-1:1]};
                    rx_tick_d  = '0;
                    rx_bit_d   = rx_bit_q + BitW'(1);
                    if (rx_bit_q == LastBit) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_sample) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
        if (rx_byte_ok) rx_data_d = rx_shift_q;
        rx_ready_d = rx_byte_ok | (rx_ready_q & ~rx_ready_clear);
    end

    always_comb begin
        unique case (rx_state_q)
            RxStart:        rx_sample = rx_clk && (rx_tick_q == HalfTick);
            RxData, RxStop: rx_sample = rx_clk && (rx_tick_q == FullTick);
            default:        rx_sample = 1'b0;
        endcase
        rx_byte_ok = (rx_state_q == RxStop) && rx_sample && rx_sync_q;
        rx_data    = rx_data_q;
        rx_ready   = rx_ready_q;
    end

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: per-cycle frame/tick model plus directed TX, RX and loopback cases.
module tb_uart;

    localparam int TxDiv = 260;
    localparam int RxDiv = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       tx_clk, rx_clk;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx, tx_busy;
    logic [7:0] rx_data;
    logic       rx, rx_drv, loop_en;
    logic       rx_ready, rx_ready_clear;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #17 sys_clk = ~sys_clk;

    assign rx = loop_en ? tx : rx_drv;

    uart #(
        .CLK_FREQ (30000000),
        .BAUD     (115200)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .tx_clk         (tx_clk),
        .rx_clk         (rx_clk),
        .tx_en          (tx_en),
        .tx_data        (tx_data),
        .tx             (tx),
        .tx_busy        (tx_busy),
        .rx_data        (rx_data),
        .rx             (rx),
        .rx_ready       (rx_ready),
        .rx_ready_clear (rx_ready_clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ticks from elapsed cycles; a frame is ten line bits, one per bit tick.
    int         m_n, m_pos;
    logic       m_busy, m_txclk, m_rxclk, m_tx;
    logic [9:0] m_frame;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_n     <= 0;
            m_pos   <= 0;
            m_busy  <= 1'b0;
            m_txclk <= 1'b0;
            m_rxclk <= 1'b0;
            m_frame <= '1;
        end else begin
            m_n     <= m_n + 1;
            m_txclk <= ((m_n + 1) % TxDiv) == 0;
            m_rxclk <= ((m_n + 1) % RxDiv) == 0;
            if (m_busy && m_txclk) begin
                if (m_pos == 10) begin
                    m_busy <= 1'b0;
                    m_pos  <= 0;
                end else begin
                    m_pos <= m_pos + 1;
                end
            end else if (!m_busy && tx_en) begin
                m_busy  <= 1'b1;
                m_frame <= {1'b1, tx_data, 1'b0};
                m_pos   <= 0;
            end
        end
    end

    assign m_tx = (m_pos >= 1) ? m_frame[m_pos-1] : 1'b1;

    logic       rx_chk;
    logic       rx_exp_ready;
    logic [7:0] rx_exp_data;

    always @(negedge sys_clk) begin
        check("tx_clk", tx_clk, m_txclk);
        check("rx_clk", rx_clk, m_rxclk);
        check("tx", tx, m_tx);
        check("tx_busy", tx_busy, m_busy);
        if (rx_chk) begin
            check("rx_ready", rx_ready, rx_exp_ready);
            check("rx_data", rx_data, rx_exp_data);
        end
    end

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (tx_busy === lvl) return;
        end
        check(name, tx_busy, lvl);
    endtask

    task automatic start_tx(input logic [7:0] b);
        tx_data = b;
        tx_en   = 1'b1;
        wait_busy(1'b1, 10, "tx accept");
        tx_en = 1'b0;
    endtask

    // Samples the ten line bits at mid-bit; returns in the middle of the stop bit.
    task automatic capture_tx(output logic [9:0] fr);
        logic found;
        found = 1'b0;
        fr    = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("tx start bit seen", found, 1);
        repeat (TxDiv / 2) @(negedge sys_clk);
        for (int i = 0; i < 10; i++) begin
            fr[i] = tx;
            if (i < 9) repeat (TxDiv) @(negedge sys_clk);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr     = {stop, b, 1'b0};
        rx_chk = 1'b0;
        rx_drv = 1'b1;
        repeat (TxDiv) @(negedge sys_clk);
        for (int i = 0; i < 10; i++) begin
            rx_drv = fr[i];
            repeat (TxDiv) @(negedge sys_clk);
        end
        rx_drv = 1'b1;
        if (stop) begin
            rx_exp_data  = b;
            rx_exp_ready = 1'b1;
        end
        rx_chk = 1'b1;
    endtask

    task automatic clear_rx();
        rx_chk         = 1'b0;
        rx_ready_clear = 1'b1;
        @(negedge sys_clk);
        rx_ready_clear = 1'b0;
        rx_exp_ready   = 1'b0;
        rx_chk         = 1'b1;
        @(negedge sys_clk);
    endtask

    initial begin
        int         ntx, nrx;
        logic [9:0] fr;
        sys_rst_n      = 1'b1;
        tx_en          = 1'b0;
        tx_data        = 8'h00;
        rx_drv         = 1'b1;
        loop_en        = 1'b0;
        rx_ready_clear = 1'b0;
        rx_chk         = 1'b1;
        rx_exp_ready   = 1'b0;
        rx_exp_data    = 8'h00;
        #1 sys_rst_n = 1'b0;

        repeat (4) @(negedge sys_clk);
        check("reset tx", tx, 1);
        check("reset tx_busy", tx_busy, 0);
        check("reset rx_ready", rx_ready, 0);
        check("reset rx_data", rx_data, 8'h00);
        check("reset tx_clk", tx_clk, 0);
        check("reset rx_clk", rx_clk, 0);

        // Idle after release: 4 bit ticks and 65 oversample ticks in 1040 cycles.
        #5 sys_rst_n = 1'b1;
        ntx = 0;
        nrx = 0;
        repeat (4 * TxDiv) begin
            @(negedge sys_clk);
            ntx += int'(tx_clk);
            nrx += int'(rx_clk);
        end
        check("tx_clk pulse count", ntx, 4);
        check("rx_clk pulse count", nrx, 65);
        check("idle tx", tx, 1);

        start_tx(8'h41);
        capture_tx(fr);
        check("frame 0x41", fr, 10'h282);
        repeat (TxDiv / 2 + 2) @(negedge sys_clk);
        check("tx_busy after stop", tx_busy, 0);
        check("tx idle after stop", tx, 1);

        tx_data = 8'h55;
        tx_en   = 1'b1;
        @(negedge sys_clk);
        tx_en = 1'b0;
        check("tx_busy on accept", tx_busy, 1);
        fork
            capture_tx(fr);
            begin
                repeat (1000) @(negedge sys_clk);
                tx_data = 8'hFF;
                tx_en   = 1'b1;
                @(negedge sys_clk);
                tx_en = 1'b0;
            end
        join
        check("frame 0x55 ignores late data", fr, 10'h2AA);
        wait_busy(1'b0, TxDiv, "tx done 0x55");

        tx_data = 8'hC3;
        tx_en   = 1'b1;
        capture_tx(fr);
        check("b2b frame 1", fr, 10'h386);
        wait_busy(1'b0, TxDiv, "b2b gap");
        wait_busy(1'b1, 4, "b2b restart");
        tx_en = 1'b0;
        capture_tx(fr);
        check("b2b frame 2", fr, 10'h386);
        wait_busy(1'b0, TxDiv, "b2b done");

        send_rx(8'hA5, 1'b1);
        check("rx_ready A5", rx_ready, 1);
        check("rx_data A5", rx_data, 8'hA5);
        clear_rx();
        check("rx_ready cleared", rx_ready, 0);
        check("rx_data kept", rx_data, 8'hA5);

        send_rx(8'h3C, 1'b0);
        check("framing error rx_ready", rx_ready, 0);
        check("framing error rx_data", rx_data, 8'hA5);

        // About 100 ns low pulse on an idle line.
        rx_drv = 1'b0;
        repeat (3) @(negedge sys_clk);
        rx_drv = 1'b1;
        repeat (12 * TxDiv) @(negedge sys_clk);
        check("glitch rx_ready", rx_ready, 0);
        check("glitch rx_data", rx_data, 8'hA5);

        send_rx(8'h12, 1'b1);
        send_rx(8'h5A, 1'b1);
        check("overwrite rx_ready", rx_ready, 1);
        check("overwrite rx_data", rx_data, 8'h5A);
        clear_rx();

        rx_chk  = 1'b0;
        loop_en = 1'b1;
        start_tx(8'h41);
        wait_busy(1'b0, 12 * TxDiv, "loopback tx done");
        rx_exp_data  = 8'h41;
        rx_exp_ready = 1'b1;
        rx_chk       = 1'b1;
        check("loopback rx_ready", rx_ready, 1);
        check("loopback rx_data", rx_data, 8'h41);

        // 0x99 has 0 in d1 and d2, so the line is low 1000 cycles after accept.
        start_tx(8'h99);
        repeat (1000) @(negedge sys_clk);
        check("mid-frame tx_busy", tx_busy, 1);
        check("mid-frame tx low", tx, 0);
        #5 sys_rst_n = 1'b0;
        rx_exp_ready = 1'b0;
        rx_exp_data  = 8'h00;
        #1;
        check("abort tx", tx, 1);
        check("abort tx_busy", tx_busy, 0);
        check("abort rx_ready", rx_ready, 0);
        check("abort rx_data", rx_data, 8'h00);
        repeat (3) @(negedge sys_clk);
        #5 sys_rst_n = 1'b1;
        repeat (2 * TxDiv) @(negedge sys_clk);
        check("post-reset tx", tx, 1);
        check("post-reset tx_busy", tx_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 Parameter CLK_FREQ, default 30000000: sys_clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200: line rate in bit/s.
REQ-003 sys_clk  input  1  single system clock; all logic on rising edge.
REQ-004 sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 tx_clk  output  1  transmit bit tick: one-sys_clk-wide pulse per bit period.
REQ-006 rx_clk  output  1  receive oversample tick: one-sys_clk-wide pulse at 16x BAUD.
REQ-007 tx_en  input  1  level request to send tx_data.
REQ-008 tx_data  input  8  byte to transmit.
REQ-009 tx  output  1  serial transmit line, idle high.
REQ-010 tx_busy  output  1  high while a frame is accepted or in flight.
REQ-011 rx_data  output  8  last correctly received byte.
REQ-012 rx  input  1  serial receive line, asynchronous, idle high.
REQ-013 rx_ready  output  1  sticky flag: new byte in rx_data.
REQ-014 rx_ready_clear  input  1  synchronous clear for rx_ready.

Function
REQ-015 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-016 TX divisor SHALL be TX_DIV = round(CLK_FREQ/BAUD), 260 at defaults; tx_clk SHALL pulse when a free-running counter wraps at TX_DIV-1.
REQ-017 RX divisor SHALL be RX_DIV = round(CLK_FREQ/(16*BAUD)), 16 at defaults; rx_clk SHALL pulse when its counter wraps at RX_DIV-1.
REQ-018 TX states SHALL be IDLE, START, DATA, STOP.
REQ-019 In IDLE with tx_en=1 on a sys_clk edge, tx_data SHALL be latched and tx_busy SHALL go high on that edge.
REQ-020 tx_en and tx_data SHALL be ignored while tx_busy=1.
REQ-021 The START bit SHALL begin at the next tx_clk tick; each bit SHALL last exactly one tx_clk period.
REQ-022 tx_busy SHALL fall on the tick ending the stop bit, and the FSM SHALL return to IDLE.
REQ-023 tx_en still high when tx_busy falls SHALL start a new frame; back-to-back frames are legal.
REQ-024 rx SHALL pass through a 2-flop synchronizer before use.
REQ-025 RX states SHALL be IDLE, START, DATA, STOP.
REQ-026 A falling edge in IDLE SHALL enter START.
REQ-027 rx low at the 8th oversample tick SHALL validate the start bit; rx high there SHALL return the FSM to IDLE as a glitch.
REQ-028 Data bits SHALL be sampled every 16 ticks thereafter, at mid-bit.
REQ-029 On a stop sample of 1, rx_data SHALL update and rx_ready SHALL be set in the same cycle.
REQ-030 On a stop sample of 0 (framing error), the byte SHALL be discarded and rx_ready left unchanged.
REQ-031 The RX FSM SHALL return to IDLE after the stop sample and rearm on the next falling edge.
REQ-032 rx_ready SHALL stay high until rx_ready_clear=1; setting SHALL win over clearing in the same cycle.
REQ-033 A new byte arriving while rx_ready=1 SHALL overwrite rx_data; no overrun flag.
REQ-034 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-035 While sys_rst_n=0: tx=1, tx_busy=0, rx_ready=0, rx_data=0, tx_clk=0, rx_clk=0, all counters 0, both FSMs IDLE, synchronizer flops 1.
REQ-036 Reset mid-frame SHALL abort the frame immediately; tx returns high without completing the frame.

Structure
REQ-037 Package uart_pkg SHALL hold the FSM state encodings, data width 8 and oversample factor 16.
REQ-038 One sub-module, uart_baud_gen, SHALL generate tx_clk and rx_clk from CLK_FREQ/BAUD; TX and RX FSMs stay in uart.

Verification
REQ-039 Reset release, no stimulus -> tx=1, tx_busy=0, rx_ready=0, rx_data=0x00; tx_clk pulse every 260 cycles; rx_clk pulse every 16 cycles.
REQ-040 tx_en=1, tx_data=0x41, held until tx_busy=1 -> tx shows 0,1,0,0,0,0,0,1,0,1, each 260 cycles; tx_busy low after the stop bit.
REQ-041 tx_en pulsed with tx_data=0x55, then tx_data=0xFF mid-frame -> transmitted byte is 0x55.
REQ-042 Drive rx with a 0xA5 frame at 115200 -> rx_data=0xA5, rx_ready=1; rx_ready_clear=1 for one cycle -> rx_ready=0.
REQ-043 0x3C frame with stop bit 0 -> rx_ready stays 0 and rx_data unchanged; a 100 ns low glitch on idle rx -> no reception.
REQ-044 tx looped back to rx, send 0x41 -> rx_ready=1, rx_data=0x41; sys_rst_n pulsed low mid-frame -> tx=1, tx_busy=0 immediately.
